dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 113 +++++++++++
 tb/tb_dmem_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin CPU/debug arbiter and fixed-latency sequencer for a single-port data memory
// Ports: clk_i/rst_i (async active-high); start_i gates new grants;
//   cpu_*: MEM-stage request, read data and pipeline stall;
//   dbg_*: debug/loader request, read data and one-cycle ack;
//   mem_*: memory enable, write enable, word-aligned address, write data and read data.
module dmem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int CW = $clog2(MEM_LAT) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              pick_dbg, busy, done;
  // grant/last encoding: 1 = debug, 0 = CPU; on a tie the port not granted last wins
  assign pick_dbg = dbg_req_i && (!cpu_req_i || !last_q);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: if (start_i && (cpu_req_i || dbg_req_i)) begin
        gnt_d   = pick_dbg;
        we_d    = pick_dbg ? dbg_we_i : cpu_we_i;
        addr_d  = pick_dbg ? dbg_addr_i : cpu_addr_i;
        wdata_d = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        cpu_rdata_d = (!we_q && !gnt_q) ? mem_rdata_i : cpu_rdata_q;
        dbg_rdata_d = (!we_q && gnt_q) ? mem_rdata_i : dbg_rdata_q;
        state_d     = DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  assign busy        = state_q == BUSY;
  assign done        = state_q == DONE;
  assign mem_en_o    = busy;
  assign mem_we_o    = busy && we_q;
  assign mem_addr_o  = busy ? (addr_q & ~ADDR_W'(3)) : '0;
  assign mem_wdata_o = busy ? wdata_q : '0;
  assign dbg_ack_o   = done && gnt_q;
  // the pipeline advances on the DONE edge of its own access
  assign cpu_stall_o = cpu_req_i && !(done && !gnt_q);
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl at MEM_LAT=2 and MEM_LAT=1
module tb_dmem_ctrl;
  logic clk = 1'b0, rst;
  logic a_start, a_cpu_req, a_cpu_we, a_dbg_req, a_dbg_we, a_stall, a_dbg_ack, a_mem_en, a_mem_we;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata, a_dbg_addr, a_dbg_wdata, a_dbg_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic b_start, b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we, b_stall, b_dbg_ack, b_mem_en, b_mem_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata, b_dbg_addr, b_dbg_wdata, b_dbg_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] mem_a [16] = '{2: 32'h5, default: 32'h0};
  logic [31:0] mem_b [16] = '{0: 32'hA1, 1: 32'hB2, default: 32'h0};
  logic [31:0] cpu_q[$], dbg_q[$], b_q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start),
    .cpu_req_i(a_cpu_req), .cpu_we_i(a_cpu_we), .cpu_addr_i(a_cpu_addr), .cpu_wdata_i(a_cpu_wdata),
    .cpu_rdata_o(a_cpu_rdata), .cpu_stall_o(a_stall),
    .dbg_req_i(a_dbg_req), .dbg_we_i(a_dbg_we), .dbg_addr_i(a_dbg_addr), .dbg_wdata_i(a_dbg_wdata),
    .dbg_rdata_o(a_dbg_rdata), .dbg_ack_o(a_dbg_ack),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_rdata_i(a_mem_rdata));

  dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start),
    .cpu_req_i(b_cpu_req), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr), .cpu_wdata_i(b_cpu_wdata),
    .cpu_rdata_o(b_cpu_rdata), .cpu_stall_o(b_stall),
    .dbg_req_i(b_dbg_req), .dbg_we_i(b_dbg_we), .dbg_addr_i(b_dbg_addr), .dbg_wdata_i(b_dbg_wdata),
    .dbg_rdata_o(b_dbg_rdata), .dbg_ack_o(b_dbg_ack),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_rdata_i(b_mem_rdata));

  assign a_mem_rdata = mem_a[a_mem_addr[5:2]];
  assign b_mem_rdata = mem_b[b_mem_addr[5:2]];
  always @(posedge clk) if (a_mem_en && a_mem_we) mem_a[a_mem_addr[5:2]] <= a_mem_wdata;
  always @(posedge clk) if (b_mem_en && b_mem_we) mem_b[b_mem_addr[5:2]] <= b_mem_wdata;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cpu(input string tag);
    int n = 0;
    while (!(a_cpu_req && !a_stall) && n < 20) begin cyc(); n++; end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_completion expected=completion", tag);
    end else chk(tag, a_cpu_rdata, cpu_q.pop_front());
  endtask

  task automatic wait_dbg(input string tag);
    int n = 0;
    while (!a_dbg_ack && n < 20) begin cyc(); n++; end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_ack expected=ack", tag);
    end else chk(tag, a_dbg_rdata, dbg_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {a_cpu_req, a_cpu_we, a_dbg_req, a_dbg_we, b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we} = '0;
    {a_cpu_addr, a_cpu_wdata, a_dbg_addr, a_dbg_wdata} = '0;
    {b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata} = '0;
    a_start = 1'b1;
    b_start = 1'b1;
    cyc(); cyc();
    chk("rst_en", a_mem_en, 0); chk("rst_we", a_mem_we, 0); chk("rst_addr", a_mem_addr, 0);
    chk("rst_wdata", a_mem_wdata, 0); chk("rst_stall", a_stall, 0); chk("rst_ack", a_dbg_ack, 0);
    chk("rst_crd", a_cpu_rdata, 0); chk("rst_drd", a_dbg_rdata, 0); chk("rst_b_en", b_mem_en, 0);
    rst = 1'b0;
    cyc();
    // single CPU read of 0x8
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h8; cpu_q.push_back(32'h5); #1;
    chk("rd_c0_stall", a_stall, 1); chk("rd_c0_en", a_mem_en, 0);
    cyc(); chk("rd_c1_en", a_mem_en, 1); chk("rd_c1_addr", a_mem_addr, 32'h8); chk("rd_c1_we", a_mem_we, 0);
    chk("rd_c1_stall", a_stall, 1);
    cyc(); chk("rd_c2_en", a_mem_en, 1); chk("rd_c2_stall", a_stall, 1);
    cyc(); chk("rd_c3_stall", a_stall, 0); chk("rd_c3_en", a_mem_en, 0);
    chk("rd_c3_data", a_cpu_rdata, cpu_q.pop_front());
    cyc(); a_cpu_req = 0;
    cyc();
    // CPU write 0x1234 to unaligned 0xD
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'hD; a_cpu_wdata = 32'h1234;
    cyc(); chk("wr_c1_en", a_mem_en, 1); chk("wr_c1_we", a_mem_we, 1); chk("wr_c1_addr", a_mem_addr, 32'hC);
    chk("wr_c1_wdata", a_mem_wdata, 32'h1234);
    cyc(); chk("wr_c2_we", a_mem_we, 1); chk("wr_c2_addr", a_mem_addr, 32'hC);
    cyc(); chk("wr_c3_stall", a_stall, 0); chk("wr_c3_rdata_hold", a_cpu_rdata, 32'h5);
    cyc(); a_cpu_req = 0;
    cyc();
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'hC; cpu_q.push_back(32'h1234);
    cyc(); wait_cpu("rd_back_c");
    cyc(); a_cpu_req = 0;
    // tie after reset: CPU first, then debug write 0x7 to 0x0
    rst = 1; cyc(); rst = 0; cyc();
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h8; cpu_q.push_back(32'h5);
    a_dbg_req = 1; a_dbg_we = 1; a_dbg_addr = 32'h0; a_dbg_wdata = 32'h7;
    cyc(); chk("tie_c1_addr", a_mem_addr, 32'h8); chk("tie_c1_we", a_mem_we, 0);
    cyc();
    cyc(); chk("tie_c3_stall", a_stall, 0); chk("tie_c3_ack", a_dbg_ack, 0);
    chk("tie_c3_data", a_cpu_rdata, cpu_q.pop_front());
    cyc(); a_cpu_req = 0; #1; chk("tie_c4_en", a_mem_en, 0);
    cyc(); chk("tie_c5_we", a_mem_we, 1); chk("tie_c5_addr", a_mem_addr, 32'h0); chk("tie_c5_wdata", a_mem_wdata, 32'h7);
    cyc(); chk("tie_c6_ack", a_dbg_ack, 0);
    cyc(); chk("tie_c7_ack", a_dbg_ack, 1); chk("tie_c7_en", a_mem_en, 0);
    chk("tie_c7_drd_hold", a_dbg_rdata, 0);
    cyc(); a_dbg_req = 0; #1; chk("tie_c8_ack", a_dbg_ack, 0);
    // second tie: debug was granted last, so CPU wins
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h0; cpu_q.push_back(32'h7);
    a_dbg_req = 1; a_dbg_we = 0; a_dbg_addr = 32'h8; dbg_q.push_back(32'h5);
    cyc(); chk("tie2_addr", a_mem_addr, 32'h0);
    wait_cpu("tie2_cpu");
    cyc(); a_cpu_req = 0;
    wait_dbg("tie2_dbg");
    cyc(); a_dbg_req = 0;
    chk("tie2_crd_hold", a_cpu_rdata, 32'h7);
    cyc();
    // start_i low blocks grants
    a_start = 0;
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h8; cpu_q.push_back(32'h5);
    a_dbg_req = 1; a_dbg_we = 0; a_dbg_addr = 32'h0; dbg_q.push_back(32'h7);
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("nostart_en", a_mem_en, 0); chk("nostart_stall", a_stall, 1);
    end
    a_start = 1;
    cyc(); chk("start_en", a_mem_en, 1); chk("start_addr", a_mem_addr, 32'h8);
    wait_cpu("start_cpu");
    cyc(); a_cpu_req = 0;
    wait_dbg("start_dbg");
    cyc(); a_dbg_req = 0;
    cyc();
    // reset during a BUSY debug write
    a_dbg_req = 1; a_dbg_we = 1; a_dbg_addr = 32'h4; a_dbg_wdata = 32'h9;
    cyc(); chk("rstm_busy", a_mem_en, 1);
    rst = 1; #1;
    chk("rstm_en", a_mem_en, 0); chk("rstm_we", a_mem_we, 0); chk("rstm_addr", a_mem_addr, 0);
    chk("rstm_wdata", a_mem_wdata, 0); chk("rstm_ack", a_dbg_ack, 0); chk("rstm_stall", a_stall, 0);
    chk("rstm_crd", a_cpu_rdata, 0); chk("rstm_drd", a_dbg_rdata, 0);
    a_dbg_req = 0;
    cyc(); chk("rstm_ack2", a_dbg_ack, 0);
    rst = 0;
    cyc(); chk("rstm_ack3", a_dbg_ack, 0);
    // MEM_LAT=1 back-to-back CPU reads of 0x0 and 0x4
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h0; b_q.push_back(32'hA1); #1;
    chk("l1_s0", b_stall, 1);
    cyc(); chk("l1_s1", b_stall, 1); chk("l1_en1", b_mem_en, 1);
    cyc(); chk("l1_s2", b_stall, 0); chk("l1_d0", b_cpu_rdata, b_q.pop_front());
    cyc(); b_cpu_addr = 32'h4; b_q.push_back(32'hB2); #1; chk("l1_s3", b_stall, 1);
    cyc(); chk("l1_s4", b_stall, 1); chk("l1_addr4", b_mem_addr, 32'h4);
    cyc(); chk("l1_s5", b_stall, 0); chk("l1_d1", b_cpu_rdata, b_q.pop_front());
    cyc(); b_cpu_req = 0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
